// File: rtl/imm_pkg.sv
// Shared definitions for the decode-path immediate generator: format codes,
// occupancy states of the two-entry output buffer and the XLEN legality check.
package imm_pkg;

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_J    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_Z    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;
    localparam logic [2:0] FMT_RSVD = 3'd7;

    // ST_ONE: only OUT holds an entry; ST_FULL: OUT and SKID both hold one.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: raw instruction + format code -> XLEN
// immediate, flagging the reserved format code.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    // Formed at 64 bits and truncated, so XLEN=32 needs no zero-width replication.
    logic [63:0] ext;

    always_comb begin
        ext     = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_I:   ext = {{52{instr[31]}}, instr[31:20]};
            FMT_S:   ext = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   ext = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_J:   ext = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            FMT_U:   ext = {{32{instr[31]}}, instr[31:12], 12'b0};
            FMT_Z:   ext = {59'b0, instr[19:15]};
            FMT_SH:  ext = 64'(instr[20 +: SHAMT_W]);
            default: illegal = 1'b1;
        endcase
    end

    assign imm = ext[XLEN-1:0];

    // Opcode bits and, at XLEN=32, the upper half of ext are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{instr[6:0], ext};

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: extracts the immediate, precomputes
// pc+imm and hands results downstream through a 2-entry skid buffer.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_fmt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    state_t            state;
    logic [XLEN-1:0]   new_imm;
    logic [XLEN-1:0]   new_tgt;
    logic              new_ill;
    logic [XLEN-1:0]   sk_imm;
    logic [XLEN-1:0]   sk_tgt;
    logic [2:0]        sk_fmt;
    logic              sk_ill;
    logic              in_xfer;
    logic              out_xfer;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .fmt     (in_fmt),
        .imm     (new_imm),
        .illegal (new_ill)
    );

    // Wraps modulo 2^XLEN; the reserved format yields imm=0 so target=pc.
    assign new_tgt  = in_pc + new_imm;
    assign in_xfer  = in_valid & in_ready & ~flush;
    assign out_xfer = out_valid & out_ready;

    // SKID is only read after being written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == ST_ONE && in_xfer && !out_xfer) begin
            sk_imm <= new_imm;
            sk_tgt <= new_tgt;
            sk_fmt <= in_fmt;
            sk_ill <= new_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_target  <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        out_imm     <= new_imm;
                        out_target  <= new_tgt;
                        out_fmt     <= in_fmt;
                        out_illegal <= new_ill;
                        out_valid   <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        in_ready <= 1'b0;
                        state    <= ST_FULL;
                    end else if (in_xfer) begin
                        out_imm     <= new_imm;
                        out_target  <= new_tgt;
                        out_fmt     <= in_fmt;
                        out_illegal <= new_ill;
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        out_imm     <= sk_imm;
                        out_target  <= sk_tgt;
                        out_fmt     <= sk_fmt;
                        out_illegal <= sk_ill;
                        in_ready    <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
